// File: rtl/wb_stage_ctrl_pkg.sv
// Shared definitions for the MEM/WB write-back stage: load size codes,
// stage state encoding and the hard-wired zero register index.
package wb_stage_ctrl_pkg;

    typedef enum logic [1:0] {
        LD_BYTE  = 2'd0,
        LD_HALF  = 2'd1,
        LD_WORD  = 2'd2,
        LD_DWORD = 2'd3
    } ld_size_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ALU_RDY = 2'd1,
        ST_LD_WAIT = 2'd2
    } wb_state_e;

    // Register 0 is hard-wired; writes to it are suppressed.
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_stage_ctrl_if.sv
// MEM -> WB upstream handshake bundle. The MEM stage is the master,
// the write-back stage is the slave that returns in_ready.
interface wb_stage_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu_result;
    logic [REG_AW-1:0] in_reg_dest;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [1:0]        in_load_size;
    logic              in_load_unsigned;
    logic [OFF_W-1:0]  in_byte_off;

    modport master (
        output in_valid, in_alu_result, in_reg_dest, in_reg_write,
               in_mem_to_reg, in_load_size, in_load_unsigned, in_byte_off,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_alu_result, in_reg_dest, in_reg_write,
               in_mem_to_reg, in_load_size, in_load_unsigned, in_byte_off,
        output in_ready
    );

endinterface

// File: rtl/wb_stage_ctrl_load_extend.sv
// Sub-word load extraction: selects the addressed little-endian lane of
// the aligned memory word and sign- or zero-extends it to DATA_W.
module wb_stage_ctrl_load_extend
    import wb_stage_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [OFF_W-1:0]  byte_off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);
    localparam int SH_W = OFF_W + 3;

    logic [SH_W-1:0]   off_s;
    logic [SH_W-1:0]   shamt_s;
    logic [DATA_W-1:0] mask_s;
    logic [DATA_W-1:0] lane_s;
    logic              sign_s;

    assign off_s = SH_W'(byte_off);

    // Lane bit shift and lane mask; dropping low offset bits aligns the lane.
    // Dword on a 32-bit datapath degenerates to the whole word.
    always_comb begin
        shamt_s = '0;
        mask_s  = '0;
        case (size)
            LD_BYTE: begin
                shamt_s = off_s << 3'd3;
                mask_s  = DATA_W'(64'h0000_0000_0000_00FF);
            end
            LD_HALF: begin
                shamt_s = (off_s >> 3'd1) << 3'd4;
                mask_s  = DATA_W'(64'h0000_0000_0000_FFFF);
            end
            LD_WORD: begin
                shamt_s = (off_s >> 3'd2) << 3'd5;
                mask_s  = DATA_W'(64'h0000_0000_FFFF_FFFF);
            end
            LD_DWORD: begin
                shamt_s = '0;
                mask_s  = '1;
            end
            default: begin
                shamt_s = '0;
                mask_s  = '1;
            end
        endcase
    end

    assign lane_s = rdata >> shamt_s;
    // Lane MSB is the bit where the mask's top set bit sits.
    assign sign_s = |(lane_s & (mask_s ^ (mask_s >> 1'b1)));
    assign data   = (lane_s & mask_s) | ((sign_s && !is_unsigned) ? ~mask_s : '0);

endmodule

// File: rtl/wb_stage_ctrl.sv
// MEM/WB write-back stage: holds the MEM/WB register, waits for late
// load data with back-pressure, and drives the register-file write port
// plus the matching WB forwarding bus.
module wb_stage_ctrl
    import wb_stage_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    wb_stage_ctrl_if.slave    stage_in,
    input  logic              flush,
    input  logic              mem_rdata_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_write_en,
    output logic [REG_AW-1:0] wb_write_reg,
    output logic [DATA_W-1:0] wb_write_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [DATA_W-1:0] fwd_data
);
    localparam int OFF_W = $clog2(DATA_W / 8);

    wb_state_e         state_r;
    wb_state_e         state_nxt_s;
    logic [DATA_W-1:0] alu_result_r;
    logic [REG_AW-1:0] reg_dest_r;
    logic              reg_write_r;
    logic [1:0]        load_size_r;
    logic              load_unsigned_r;
    logic [OFF_W-1:0]  byte_off_r;

    logic              in_ready_s;
    logic              capture_s;
    logic              dest_live_s;
    logic              write_en_s;
    logic [REG_AW-1:0] write_reg_s;
    logic [DATA_W-1:0] write_data_s;
    logic [DATA_W-1:0] load_data_s;

    wb_stage_ctrl_load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .size        (load_size_r),
        .is_unsigned (load_unsigned_r),
        .byte_off    (byte_off_r),
        .rdata       (mem_rdata),
        .data        (load_data_s)
    );

    // A flush blocks capture even though in_ready still reflects the state.
    assign capture_s   = stage_in.in_valid && in_ready_s && !flush;
    assign dest_live_s = reg_write_r && (reg_dest_r != REG_AW'(REG_ZERO));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // MEM/WB pipeline register: cleared on reset/flush, loaded on capture.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            alu_result_r    <= '0;
            reg_dest_r      <= '0;
            reg_write_r     <= 1'b0;
            load_size_r     <= 2'd0;
            load_unsigned_r <= 1'b0;
            byte_off_r      <= '0;
        end else if (capture_s) begin
            alu_result_r    <= stage_in.in_alu_result;
            reg_dest_r      <= stage_in.in_reg_dest;
            reg_write_r     <= stage_in.in_reg_write;
            load_size_r     <= stage_in.in_load_size;
            load_unsigned_r <= stage_in.in_load_unsigned;
            byte_off_r      <= stage_in.in_byte_off;
        end
    end

    // Next-state logic: flush wins, then a new capture, else retire or hold.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = ST_EMPTY;
        end else if (capture_s) begin
            state_nxt_s = stage_in.in_mem_to_reg ? ST_LD_WAIT : ST_ALU_RDY;
        end else begin
            case (state_r)
                ST_EMPTY:   state_nxt_s = ST_EMPTY;
                ST_ALU_RDY: state_nxt_s = ST_EMPTY;
                ST_LD_WAIT: state_nxt_s = mem_rdata_valid ? ST_EMPTY : ST_LD_WAIT;
                default:    state_nxt_s = ST_EMPTY;
            endcase
        end
    end

    // Output decode: write strobe, address, data and upstream ready.
    always_comb begin
        in_ready_s   = 1'b1;
        write_en_s   = 1'b0;
        write_reg_s  = '0;
        write_data_s = '0;
        case (state_r)
            ST_EMPTY: begin
                in_ready_s = 1'b1;
            end
            ST_ALU_RDY: begin
                write_reg_s  = reg_dest_r;
                write_data_s = alu_result_r;
                write_en_s   = dest_live_s && !flush;
            end
            ST_LD_WAIT: begin
                write_reg_s = reg_dest_r;
                in_ready_s  = mem_rdata_valid;
                if (mem_rdata_valid) begin
                    write_data_s = load_data_s;
                    write_en_s   = dest_live_s && !flush;
                end else begin
                    write_data_s = '0;
                    write_en_s   = 1'b0;
                end
            end
            default: begin
                in_ready_s = 1'b1;
            end
        endcase
    end

    assign stage_in.in_ready = in_ready_s;
    assign wb_write_en       = write_en_s;
    assign wb_write_reg      = write_reg_s;
    assign wb_write_data     = write_data_s;
    assign fwd_valid         = write_en_s;
    assign fwd_reg           = write_reg_s;
    assign fwd_data          = write_data_s;

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Self-checking bench for wb_stage_ctrl: directed scenarios on a 32-bit
// and a 64-bit instance plus randomized traffic against a reference model.
module tb_wb_stage_ctrl;
    import wb_stage_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        reset;
    logic        flush, rv;
    logic [31:0] rdata;
    logic        en, fen;
    logic [4:0]  wreg, freg;
    logic [31:0] wdata, fdata;

    logic        flush64, rv64;
    logic [63:0] rdata64;
    logic        en64, fen64;
    logic [4:0]  wreg64, freg64;
    logic [63:0] wdata64, fdata64;

    wb_stage_ctrl_if #(.DATA_W(32), .REG_AW(5)) bus ();
    wb_stage_ctrl_if #(.DATA_W(64), .REG_AW(5)) bus64 ();

    wb_stage_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .reset(reset), .stage_in(bus.slave), .flush(flush),
        .mem_rdata_valid(rv), .mem_rdata(rdata),
        .wb_write_en(en), .wb_write_reg(wreg), .wb_write_data(wdata),
        .fwd_valid(fen), .fwd_reg(freg), .fwd_data(fdata)
    );

    wb_stage_ctrl #(.DATA_W(64), .REG_AW(5)) dut64 (
        .clk(clk), .reset(reset), .stage_in(bus64.slave), .flush(flush64),
        .mem_rdata_valid(rv64), .mem_rdata(rdata64),
        .wb_write_en(en64), .wb_write_reg(wreg64), .wb_write_data(wdata64),
        .fwd_valid(fen64), .fwd_reg(freg64), .fwd_data(fdata64)
    );

    // Reference model state: the single instruction held in WB, if any.
    logic        m_valid, m_load, m_rw, m_uns;
    logic [4:0]  m_dest;
    logic [31:0] m_alu;
    logic [1:0]  m_size, m_off;

    // Lane extraction from first principles: lane size in bytes, lane index
    // by integer division, then mask and optional sign fill.
    function automatic logic [63:0] ref_extract(input int dw, input logic [1:0] size,
                                                input logic uns, input int off,
                                                input logic [63:0] word);
        int nbytes;
        int bits;
        int lane;
        logic [63:0] val;
        logic [63:0] mask;
        nbytes = (size == 2'd3) ? dw / 8 : (1 << size);
        bits   = nbytes * 8;
        lane   = off / nbytes;
        val    = word >> (lane * bits);
        mask   = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        val    = val & mask;
        if (!uns && val[bits-1]) val = val | ~mask;
        if (dw == 32) val = val & 64'h0000_0000_FFFF_FFFF;
        return val;
    endfunction

    task automatic set_op(input logic v, input logic [31:0] alu, input logic [4:0] d,
                          input logic rw, input logic m2r, input logic [1:0] sz,
                          input logic u, input logic [1:0] off);
        bus.in_valid = v; bus.in_alu_result = alu; bus.in_reg_dest = d;
        bus.in_reg_write = rw; bus.in_mem_to_reg = m2r; bus.in_load_size = sz;
        bus.in_load_unsigned = u; bus.in_byte_off = off;
    endtask

    task automatic set_op64(input logic v, input logic [4:0] d, input logic [1:0] sz,
                            input logic u, input logic [2:0] off);
        bus64.in_valid = v; bus64.in_alu_result = 64'd0; bus64.in_reg_dest = d;
        bus64.in_reg_write = 1'b1; bus64.in_mem_to_reg = 1'b1; bus64.in_load_size = sz;
        bus64.in_load_unsigned = u; bus64.in_byte_off = off;
    endtask

    task automatic idle32;
        set_op(1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0);
        flush = 1'b0; rv = 1'b0; rdata = 32'd0;
    endtask

    task automatic idle64;
        set_op64(1'b0, 5'd0, 2'd0, 1'b0, 3'd0);
        flush64 = 1'b0; rv64 = 1'b0; rdata64 = 64'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1; idle32(); idle64();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.in_ready); end
        checks++; if ({en, wreg, wdata, fen, freg, fdata} !== 76'd0) begin errors++; $display("FAIL reset_outputs32: got en=%b reg=%0d data=%h fwd=%b/%0d/%h want all 0", en, wreg, wdata, fen, freg, fdata); end
        checks++; if ({bus64.in_ready, en64, fen64, wreg64, wdata64} !== {1'b1, 2'b00, 5'd0, 64'd0}) begin errors++; $display("FAIL reset_outputs64: got rdy=%b en=%b fwd=%b reg=%0d data=%h", bus64.in_ready, en64, fen64, wreg64, wdata64); end
        reset = 1'b0;
    endtask

    task automatic test_alu;
        @(negedge clk); idle32();
        set_op(1'b1, 32'h1234_5678, 5'd8, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alu_accept_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); idle32(); #1;
        checks++; if ({en, wreg, wdata} !== {1'b1, 5'd8, 32'h1234_5678}) begin errors++; $display("FAIL alu_write: got en=%b reg=%0d data=%h want 1/8/12345678", en, wreg, wdata); end
        checks++; if ({fen, freg, fdata} !== {1'b1, 5'd8, 32'h1234_5678}) begin errors++; $display("FAIL alu_fwd: got %b/%0d/%h want 1/8/12345678", fen, freg, fdata); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %b want 1", bus.in_ready); end
        @(negedge clk); #1;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL alu_retired: got en=%b want 0", en); end
    endtask

    task automatic test_lb_wait;
        @(negedge clk); idle32();
        set_op(1'b1, 32'd0, 5'd9, 1'b1, 1'b1, 2'd0, 1'b0, 2'd3);
        rdata = 32'h80FF_0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); bus.in_valid = 1'b0; #1;
            checks++; if ({bus.in_ready, en} !== 2'b00) begin errors++; $display("FAIL lb_stall%0d: got rdy=%b en=%b want 0/0", i, bus.in_ready, en); end
        end
        @(negedge clk); rv = 1'b1; #1;
        checks++; if ({en, wreg, wdata, bus.in_ready} !== {1'b1, 5'd9, 32'hFFFF_FF80, 1'b1}) begin errors++; $display("FAIL lb_write: got en=%b reg=%0d data=%h rdy=%b want 1/9/ffffff80/1", en, wreg, wdata, bus.in_ready); end
    endtask

    task automatic test_lhu;
        @(negedge clk); idle32();
        set_op(1'b1, 32'd0, 5'd10, 1'b1, 1'b1, 2'd1, 1'b1, 2'd2);
        rdata = 32'h8001_1234; rv = 1'b1;
        @(negedge clk); bus.in_valid = 1'b0; #1;
        checks++; if ({en, wreg, wdata} !== {1'b1, 5'd10, 32'h0000_8001}) begin errors++; $display("FAIL lhu_write: got en=%b reg=%0d data=%h want 1/10/00008001", en, wreg, wdata); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle32();
            if (i < 3) set_op(1'b1, 32'hA000_0000 + 32'(i), 5'(i + 1), 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.in_ready); end
            if (i > 0) begin
                checks++;
                if ({en, wreg, wdata} !== {1'b1, 5'(i), 32'hA000_0000 + 32'(i - 1)}) begin
                    errors++; $display("FAIL b2b_write%0d: got en=%b reg=%0d data=%h want 1/%0d/%h", i, en, wreg, wdata, i, 32'hA000_0000 + 32'(i - 1));
                end
            end
        end
    endtask

    task automatic test_reg0;
        @(negedge clk); idle32();
        set_op(1'b1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        @(negedge clk);
        set_op(1'b1, 32'h5555_0005, 5'd5, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        #1;
        checks++; if ({en, fen, bus.in_ready} !== 3'b001) begin errors++; $display("FAIL reg0_suppress: got en=%b fwd=%b rdy=%b want 0/0/1", en, fen, bus.in_ready); end
        @(negedge clk); idle32(); #1;
        checks++; if ({en, wreg, wdata} !== {1'b1, 5'd5, 32'h5555_0005}) begin errors++; $display("FAIL reg0_retire: got en=%b reg=%0d data=%h want 1/5/55550005", en, wreg, wdata); end
    endtask

    task automatic test_flush;
        @(negedge clk); idle32();
        set_op(1'b1, 32'd0, 5'd11, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
        @(negedge clk); bus.in_valid = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre_stall: got rdy=%b want 0", bus.in_ready); end
        @(negedge clk);
        set_op(1'b1, 32'h7777_0007, 5'd12, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0);
        flush = 1'b1; #1;
        checks++; if ({en, fen} !== 2'b00) begin errors++; $display("FAIL flush_nowrite: got en=%b fwd=%b want 0/0", en, fen); end
        @(negedge clk); idle32(); rv = 1'b1; rdata = 32'hCAFE_F00D; #1;
        checks++; if ({en, fen, bus.in_ready} !== 3'b001) begin errors++; $display("FAIL flush_late_data: got en=%b fwd=%b rdy=%b want 0/0/1", en, fen, bus.in_ready); end
        @(negedge clk); idle32(); #1;
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL flush_no_capture: got en=%b want 0", en); end
    endtask

    task automatic test_reset_ldwait;
        @(negedge clk); idle32();
        set_op(1'b1, 32'd0, 5'd13, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0);
        @(negedge clk); bus.in_valid = 1'b0; #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_stall: got rdy=%b want 0", bus.in_ready); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0; rv = 1'b1; rdata = 32'h1111_2222; #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready: got %b want 1", bus.in_ready); end
        checks++; if ({en, wreg, wdata, fen, freg, fdata} !== 76'd0) begin errors++; $display("FAIL rst_ld_outputs: got en=%b reg=%0d data=%h fwd=%b want all 0", en, wreg, wdata, fen); end
    endtask

    task automatic test_dw64;
        @(negedge clk); idle64();
        set_op64(1'b1, 5'd7, 2'd2, 1'b0, 3'd4);
        rdata64 = 64'h8000_0000_0000_0001; rv64 = 1'b1;
        @(negedge clk); bus64.in_valid = 1'b0; #1;
        checks++; if ({en64, wreg64, wdata64} !== {1'b1, 5'd7, 64'hFFFF_FFFF_8000_0000}) begin errors++; $display("FAIL lw64_write: got en=%b reg=%0d data=%h want 1/7/ffffffff80000000", en64, wreg64, wdata64); end
        checks++; if ({fen64, freg64, fdata64} !== {1'b1, 5'd7, 64'hFFFF_FFFF_8000_0000}) begin errors++; $display("FAIL lw64_fwd: got %b/%0d/%h", fen64, freg64, fdata64); end
    endtask

    task automatic test_load64_random;
        logic [1:0]  sz;
        logic        u;
        logic [2:0]  off;
        logic [4:0]  d;
        logic [63:0] exp;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); idle64();
            sz = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1));
            off = 3'($urandom_range(0, 7)); d = 5'($urandom_range(1, 31));
            set_op64(1'b1, d, sz, u, off);
            rdata64 = {$urandom, $urandom}; rv64 = 1'b1;
            exp = ref_extract(64, sz, u, int'(off), rdata64);
            @(negedge clk); bus64.in_valid = 1'b0; #1;
            checks++;
            if ({en64, wreg64, wdata64} !== {1'b1, d, exp}) begin
                errors++; $display("FAIL load64_rand%0d: size=%0d off=%0d uns=%b got en=%b reg=%0d data=%h want 1/%0d/%h", i, sz, off, u, en64, wreg64, wdata64, d, exp);
            end
        end
        @(negedge clk); idle64();
    endtask

    task automatic test_random32;
        logic        exp_ready, exp_en;
        logic [31:0] exp_data;
        m_valid = 1'b0; m_load = 1'b0; m_rw = 1'b0; m_uns = 1'b0;
        m_dest = 5'd0; m_alu = 32'd0; m_size = 2'd0; m_off = 2'd0;
        @(negedge clk); idle32(); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        for (int c = 0; c < 500; c++) begin
            set_op(1'($urandom_range(0, 3) != 0), $urandom,
                   ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            flush = ($urandom_range(0, 15) == 0);
            rv    = ($urandom_range(0, 2) == 0);
            rdata = $urandom;
            #1;
            exp_ready = !m_valid || !m_load || rv;
            exp_en    = m_valid && !flush && (!m_load || rv) && m_rw && (m_dest != 5'd0);
            exp_data  = m_load ? ref_extract(32, m_size, m_uns, int'(m_off), {32'd0, rdata}) : m_alu;
            checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rand_ready@%0d: got %b want %b", c, bus.in_ready, exp_ready); end
            checks++; if ({en, fen} !== {exp_en, exp_en}) begin errors++; $display("FAIL rand_en@%0d: got en=%b fwd=%b want %b", c, en, fen, exp_en); end
            if (m_valid) begin
                checks++; if (wreg !== m_dest) begin errors++; $display("FAIL rand_reg@%0d: got %0d want %0d", c, wreg, m_dest); end
            end
            if (exp_en) begin
                checks++; if ({wdata, freg, fdata} !== {exp_data, m_dest, exp_data}) begin errors++; $display("FAIL rand_data@%0d: got data=%h fwd=%0d/%h want %h/%0d", c, wdata, freg, fdata, exp_data, m_dest); end
            end
            // Advance the model to what the stage holds after this edge.
            if (flush) begin
                m_valid = 1'b0;
            end else if (exp_ready) begin
                m_valid = bus.in_valid;
                m_load  = bus.in_mem_to_reg; m_alu = bus.in_alu_result;
                m_dest  = bus.in_reg_dest;   m_rw  = bus.in_reg_write;
                m_size  = bus.in_load_size;  m_uns = bus.in_load_unsigned;
                m_off   = bus.in_byte_off;
            end
            @(negedge clk);
        end
        idle32();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lb_wait();
        test_lhu();
        test_back_to_back();
        test_reg0();
        test_flush();
        test_reset_ldwait();
        test_dw64();
        test_load64_random();
        test_random32();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_stage_ctrl.md
Name: wb_stage_ctrl

Overview:
Parametrised MEM/WB write-back stage for the pipelined MIPS core. It owns the MEM/WB pipeline register, selects the write-back source, and extracts and extends sub-word loads. It waits for late memory read data with a valid/ready handshake and back-pressure. It drives the register-file write port and the WB forwarding bus.

Parameters:
DATA_W, 32, datapath width; legal values 32 or 64.
REG_AW, 5, register-file address width.
OFF_W, $clog2(DATA_W/8), byte-offset width (derived; not overridden).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept this cycle
in_alu_result  in  DATA_W  ALU result / effective address
in_reg_dest  in  REG_AW  destination register
in_reg_write  in  1  instruction writes the register file
in_mem_to_reg  in  1  1 = load; write-back data comes from memory
in_load_size  in  2  0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only)
in_load_unsigned  in  1  zero-extend instead of sign-extend
in_byte_off  in  OFF_W  byte offset of the load within the memory word
flush  in  1  discard the held entry
mem_rdata_valid  in  1  memory read data valid this cycle
mem_rdata  in  DATA_W  memory read data, naturally aligned word
wb_write_en  out  1  register-file write strobe
wb_write_reg  out  REG_AW  register-file write address
wb_write_data  out  DATA_W  register-file write data
fwd_valid  out  1  forwarding bus valid
fwd_reg  out  REG_AW  forwarding register
fwd_data  out  DATA_W  forwarding data

Behaviour:
- States: EMPTY, ALU_RDY, LD_WAIT. The MEM/WB register captures all in_* fields on the edge where in_valid && in_ready.
- Next state after capture: ALU_RDY if in_mem_to_reg=0, else LD_WAIT.
- Reset: state EMPTY, MEM/WB register cleared, all outputs 0, in_ready=1.
- EMPTY:
  - in_ready=1, wb_write_en=0.
- ALU_RDY (entry retires in this cycle):
  - wb_write_data = alu_result.
  - wb_write_en = reg_write && (reg_dest != 0).
  - in_ready=1.
  - Next state: new capture state, or EMPTY.
- LD_WAIT:
  - If mem_rdata_valid=1: write occurs this cycle with the extracted data, in_ready=1, entry retires.
  - Else: wb_write_en=0, in_ready=0, entry held; no timeout.
- Load extraction, little-endian:
  - byte: lane byte_off.
  - half: lane byte_off[OFF_W-1:1].
  - word: for DATA_W=32 the whole word; for DATA_W=64, lane byte_off[2].
  - dword: whole word.
  - Low bits of the offset below the access size are ignored; misalignment is not trapped.
  - Sign-extend from the lane MSB unless in_load_unsigned=1.
  - size 3 with DATA_W=32 is treated as word.
- Write-back address: wb_write_reg = held reg_dest in every non-EMPTY state.
- Forwarding bus: fwd_valid/fwd_reg/fwd_data mirror wb_write_en/wb_write_reg/wb_write_data in the same cycle (combinational).
- Register-0 rule: reg_dest=0 never asserts wb_write_en or fwd_valid, but the entry still retires normally.
- flush (priority over everything except reset):
  - Held entry dropped, no write that cycle, state EMPTY next.
  - An in_valid presented in the same cycle is not captured.
  - in_ready is still driven per the current state, so an upstream flush must be asserted coherently.
- mem_rdata_valid in EMPTY/ALU_RDY is ignored.
- Reset mid-LD_WAIT: the entry is abandoned; a later mem_rdata_valid is ignored.
- Throughput: one instruction per cycle when no load waits. Latency is 1 cycle from capture to write for ALU ops, and 1+N cycles for loads, where N is the number of cycles mem_rdata_valid is low.

Decomposition:
- Shared core package:
  - load size encodings LD_BYTE/LD_HALF/LD_WORD/LD_DWORD;
  - wb state enum;
  - REG_ZERO constant.
- Sub-module load_extend: combinational lane select plus sign/zero extension, parametrised by DATA_W.
- The FSM and the MEM/WB register stay in wb_stage_ctrl.

Test Plan:
- ALU op, reg 8, result 0x1234_5678, reg_write=1:
  - next cycle wb_write_en=1, reg 8, data 0x1234_5678;
  - fwd_* identical;
  - in_ready stays 1.
- lb, off=3, unsigned=0, mem_rdata=0x80FF_0000, valid 2 cycles after capture:
  - in_ready=0 for 2 cycles;
  - then write 0xFFFF_FF80 to the destination.
- lhu, off=2, mem_rdata=0x8001_1234, valid immediately:
  - write 0x0000_8001 in the cycle after capture.
- Back-to-back ALU ops to regs 1,2,3:
  - writes on 3 consecutive cycles, no stalls.
- ALU op to reg 0 with reg_write=1:
  - wb_write_en=0, fwd_valid=0, entry retires.
- Load in LD_WAIT, flush asserted with in_valid=1:
  - no write;
  - next state EMPTY;
  - new op not captured;
  - a later mem_rdata_valid is ignored.
- Reset asserted in LD_WAIT: all outputs 0 next cycle, in_ready=1.
- DATA_W=64, lw, off=4, mem_rdata=0x8000_0000_0000_0001:
  - write 0xFFFF_FFFF_8000_0000.
